// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// interrupt_controller_pkg
// Shared constants and state encoding for the interrupt controller.
// Rev 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

    localparam logic [1:0] IRQ_REG_ENABLE  = 2'd0;
    localparam logic [1:0] IRQ_REG_EDGE    = 2'd1;
    localparam logic [1:0] IRQ_REG_PENDING = 2'd2;
    localparam logic [1:0] IRQ_REG_STATUS  = 2'd3;

    localparam int IRQ_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_ACTIVE  = 2'd2
    } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/interrupt_controller_if.sv
`default_nettype none
// ============================================================================
// interrupt_controller_if
// Interrupt lines, config register port and claim/complete handshake.
// Rev 1.0 - initial release
// ============================================================================
interface interrupt_controller_if
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ = 16
);
    logic [NUM_IRQ-1:0]      irqIn;
    logic                    cfgWriteEnable;
    logic [1:0]              cfgAddress;
    logic [15:0]             cfgWriteData;
    logic [15:0]             cfgReadData;
    logic [15:0]             userInterrupts;
    logic                    irqValid;
    logic [IRQ_ID_WIDTH-1:0] irqId;
    logic                    irqClaim;
    logic                    irqComplete;

    modport master (
        output irqIn, cfgWriteEnable, cfgAddress, cfgWriteData, irqClaim, irqComplete,
        input  cfgReadData, userInterrupts, irqValid, irqId
    );

    modport slave (
        input  irqIn, cfgWriteEnable, cfgAddress, cfgWriteData, irqClaim, irqComplete,
        output cfgReadData, userInterrupts, irqValid, irqId
    );

endinterface
`default_nettype wire

// File: rtl/irq_line_sync.sv
`default_nettype none
// ============================================================================
// irq_line_sync
// Per-line synchroniser, rising-edge detect and pending bit (edge or level).
// Rev 1.0 - initial release
// ============================================================================
module irq_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_raw,
    input  logic edge_mode,
    input  logic clear,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   synced;
    logic                   synced_prev;
    logic                   rise;

    assign synced = sync_chain[SYNC_STAGES-1];
    assign rise   = synced & ~synced_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain  <= '0;
            synced_prev <= 1'b0;
        end else begin
            sync_chain  <= {sync_chain[SYNC_STAGES-2:0], irq_raw};
            synced_prev <= synced;
        end
    end

    // A new edge beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (edge_mode) begin
            if (rise) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end else begin
            pending <= synced;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// interrupt_controller
// Arbitrates up to 16 lines and presents one at a time via claim/complete.
// Optional macro INTERRUPT_CONTROLLER_ROUND_ROBIN_EN selects round-robin.
// Rev 1.0 - initial release
// ============================================================================
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus
);

    localparam int ID_W = IRQ_ID_WIDTH;

    logic [NUM_IRQ-1:0] enable_reg;
    logic [NUM_IRQ-1:0] edge_reg;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] candidates;
    logic [NUM_IRQ-1:0] line_clear;
    logic [NUM_IRQ-1:0] pend_write_clear;
    logic [15:0]        pending_ext;
    logic [15:0]        enable_ext;
    logic [15:0]        edge_ext;
    logic [15:0]        cand_ext;

    irq_state_t         state;
    irq_state_t         state_next;
    logic [ID_W-1:0]    irq_id;
    logic [ID_W-1:0]    winner;
    logic               any_candidate;
    logic               presented_live;
    logic               claim_fire;

    assign candidates     = pending & enable_ext[NUM_IRQ-1:0];
    assign pending_ext    = 16'(pending);
    assign enable_ext     = 16'(enable_reg);
    assign edge_ext       = 16'(edge_reg);
    assign cand_ext       = 16'(candidates);
    assign any_candidate  = |candidates;
    assign presented_live = cand_ext[irq_id];
    assign claim_fire     = (state == ST_PRESENT) && bus.irqClaim;

    assign pend_write_clear = (bus.cfgWriteEnable && bus.cfgAddress == IRQ_REG_PENDING)
                            ? bus.cfgWriteData[NUM_IRQ-1:0] : '0;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        assign line_clear[i] = pend_write_clear[i] | (claim_fire && irq_id == ID_W'(i));

        irq_line_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .irq_raw   (bus.irqIn[i]),
            .edge_mode (edge_reg[i]),
            .clear     (line_clear[i]),
            .pending   (pending[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_reg <= '0;
            edge_reg   <= '0;
        end else if (bus.cfgWriteEnable) begin
            if (bus.cfgAddress == IRQ_REG_ENABLE) begin
                enable_reg <= bus.cfgWriteData[NUM_IRQ-1:0];
            end
            if (bus.cfgAddress == IRQ_REG_EDGE) begin
                edge_reg <= bus.cfgWriteData[NUM_IRQ-1:0];
            end
        end
    end

`ifdef INTERRUPT_CONTROLLER_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_claimed;
    int              rr_idx;
    logic            rr_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_claimed <= ID_W'(NUM_IRQ - 1);
        end else if (claim_fire) begin
            last_claimed <= irq_id;
        end
    end

    // Search begins one past the most recently claimed line and wraps.
    always_comb begin
        winner   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            rr_idx = int'(last_claimed) + 1 + k;
            if (rr_idx >= NUM_IRQ) begin
                rr_idx = rr_idx - NUM_IRQ;
            end
            if (!rr_found && cand_ext[rr_idx[ID_W-1:0]]) begin
                winner   = rr_idx[ID_W-1:0];
                rr_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_id <= '0;
        end else if (state == ST_IDLE && any_candidate) begin
            irq_id <= winner;
        end
    end

    // A claim landing together with a vanishing candidate still commits to ACTIVE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_candidate) begin
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (bus.irqClaim) begin
                    state_next = ST_ACTIVE;
                end else if (!presented_live) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.irqComplete) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.irqValid       = 1'b0;
        bus.userInterrupts = '0;
        if (state == ST_PRESENT) begin
            bus.irqValid       = 1'b1;
            bus.userInterrupts = 16'd1 << irq_id;
        end
    end

    assign bus.irqId = irq_id;

    always_comb begin
        bus.cfgReadData = '0;
        case (bus.cfgAddress)
            IRQ_REG_ENABLE:  bus.cfgReadData = enable_ext;
            IRQ_REG_EDGE:    bus.cfgReadData = edge_ext;
            IRQ_REG_PENDING: bus.cfgReadData = pending_ext;
            IRQ_REG_STATUS:  bus.cfgReadData = {state, 6'b0, irq_id, pending_ext[3:0]};
            default:         bus.cfgReadData = '0;
        endcase
    end

endmodule
`default_nettype wire
